elevator_request_scheduler: RTL and testbench
=============================================

# elevator_request_scheduler

Upstream stage of `elevator_control_top`. Latches floor calls from car and hall buttons into a pending-request bitmap. Selects the next target floor with a SCAN (sweep up, then sweep down) policy and presents it on `requested_floor` to the controller. Clears a request when the controller reports arrival at that floor.

## Interface
Parameters:
- `NUM_FLOORS`, 16: number of served floors; must be ≤ 2^`FLOOR_W`.
- `FLOOR_W`, 4: floor index width.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `call_valid`  in  1  one-cycle strobe: a button press.
- `call_floor`  in  `FLOOR_W`  floor of the press, sampled when `call_valid`=1.
- `current_floor`  in  `FLOOR_W`  from controller `current_floor`.
- `arrived`  in  1  one-cycle strobe from controller: stopped at `current_floor`, request served.
- `door_open`  in  1  from controller `door_open`.
- `requested_floor`  out  `FLOOR_W`  target floor to controller, registered.
- `req_valid`  out  1  `requested_floor` is meaningful, registered.
- `direction`  out  1  sweep direction: 1=up, 0=down, registered.
- `pending`  out  `NUM_FLOORS`  outstanding-request bitmap, registered.

## Operation
- Reset (`reset`=0, asynchronous): `pending`=0, `requested_floor`=0, `req_valid`=0, `direction`=1, state IDLE.
- Request capture:
  - `call_valid` with `call_floor` < `NUM_FLOORS` sets `pending[call_floor]`.
  - Out-of-range floors are ignored.
  - Repeated calls to a floor that is already pending have no effect.
- Request clear: `arrived`=1 clears `pending[current_floor]`.
  - Same-cycle `call_valid` to that same floor: the clear wins and the bit ends at 0.
  - Same-cycle call to any other floor is captured normally.
- State machine: IDLE, UP, DOWN. Evaluated on the registered `pending`.
  - IDLE: `pending`=0 → stay.
  - IDLE → UP if any pending floor ≥ `current_floor`; otherwise IDLE → DOWN. A request at `current_floor` goes to UP.
  - UP: target = lowest pending floor ≥ `current_floor`.
  - UP with none above or at `current_floor`: → DOWN if any pending floor remains, else → IDLE.
  - DOWN: target = highest pending floor ≤ `current_floor`.
  - DOWN with none below or at `current_floor`: → UP if any pending floor remains, else → IDLE.
- Outputs:
  - `direction` = 1 in UP, 0 in DOWN, and holds its last value in IDLE.
  - `req_valid` = 1 in UP/DOWN, 0 in IDLE.
  - `requested_floor` holds its last value when `req_valid`=0.
- Door hold: while `door_open`=1, state, `direction` and `requested_floor` are frozen. `pending` capture and clear continue.
- Retargeting: a new call closer in the current sweep direction replaces `requested_floor` (when the door is closed). Calls behind the car wait for the reverse sweep.

## Timing
- `call_valid` at edge N → `pending` bit set after edge N.
- Same call → `requested_floor`/`req_valid`/`direction` updated after edge N+1. Total latency: 2 cycles.
- `arrived` at edge N → bit cleared after N. Next target or IDLE after N+1, unless `door_open`=1, which delays the update to the edge after `door_open` falls.
- All outputs change only on the rising `clk` edge, except the asynchronous reset assertion.
- Reset deasserts synchronously to `clk` (external synchronizer). Reset mid-sweep discards all pending requests.
- No combinational path from inputs to outputs.

## Test plan
- Reset, `current_floor`=0, call floor 3 → two cycles later `req_valid`=1, `requested_floor`=3, `direction`=1, `pending`=0x0008.
- Car at 1 in UP with target 5, call floor 3 (door closed) → `requested_floor`=3. Then `arrived` at 3 → `pending[3]`=0, and one cycle later `requested_floor`=5.
- Car at 4 in UP, pending {2,6}: serve 6 (`arrived`) → state DOWN, `direction`=0, `requested_floor`=2. `arrived` at 2 → `req_valid`=0, IDLE.
- Same cycle: `arrived` at floor 3 and `call_valid` floor 3 → `pending[3]`=0. Same cycle: `call_valid` floor 7 with `arrived` at 3 → `pending[7]`=1.
- `door_open`=1 at floor 2 in UP, target 8, call floor 4 → `requested_floor` stays 8 until `door_open` falls, then becomes 4 one cycle later. `call_floor`=15 with `NUM_FLOORS`=10 → ignored.
- Assert `reset` low mid-sweep with `pending`=0x0124 → `pending`=0, `req_valid`=0, `requested_floor`=0, `direction`=1 immediately, without waiting for a clock.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: latches floor calls into a pending bitmap and picks
// the next target floor with a SCAN sweep policy.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS = 16,
  parameter int FLOOR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  arrived,
  input  logic                  door_open,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic                  req_valid,
  output logic                  direction,
  output logic [NUM_FLOORS-1:0] pending
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t state, nxt;
  logic up_hit, dn_hit;
  logic [FLOOR_W-1:0] up_tgt, dn_tgt;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  // Shifting past the bitmap width yields zero, so out-of-range floors drop out.
  assign set_mask = call_valid ? NUM_FLOORS'(1) << call_floor : '0;
  assign clr_mask = arrived ? NUM_FLOORS'(1) << current_floor : '0;
  always_comb begin
    up_hit = 1'b0;
    dn_hit = 1'b0;
    up_tgt = '0;
    dn_tgt = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && FLOOR_W'(i) >= current_floor) begin
        up_hit = 1'b1;
        up_tgt = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && FLOOR_W'(i) <= current_floor) begin
        dn_hit = 1'b1;
        dn_tgt = FLOOR_W'(i);
      end
    nxt = ~|pending ? IDLE : state == DOWN ? (dn_hit ? DOWN : UP) : (up_hit ? UP : DOWN);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      pending         <= '0;
      requested_floor <= '0;
      req_valid       <= 1'b0;
      direction       <= 1'b1;
    end else begin
      pending <= (pending | set_mask) & ~clr_mask;
      if (!door_open) begin
        state           <= nxt;
        req_valid       <= nxt != IDLE;
        direction       <= nxt == IDLE ? direction : nxt == UP;
        requested_floor <= nxt == UP ? up_tgt : nxt == DOWN ? dn_tgt : requested_floor;
      end
    end
  end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb_elevator_request_scheduler: directed vectors for the SCAN request scheduler.
module tb_elevator_request_scheduler;
  localparam int NF = 10;
  localparam int FW = 4;
  logic clk, reset, call_valid, arrived, door_open;
  logic [FW-1:0] call_floor, current_floor, requested_floor;
  logic req_valid, direction;
  logic [NF-1:0] pending;
  int total = 0, bad = 0;

  elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .current_floor(current_floor), .arrived(arrived), .door_open(door_open),
    .requested_floor(requested_floor), .req_valid(req_valid), .direction(direction),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic call(input int f);
    call_valid = 1'b1;
    call_floor = FW'(f);
    tick();
    call_valid = 1'b0;
  endtask

  task automatic arrive(input int f);
    current_floor = FW'(f);
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
  endtask

  initial begin
    reset = 1'b0; call_valid = 1'b0; arrived = 1'b0; door_open = 1'b0;
    call_floor = '0; current_floor = '0;
    tick();
    tick();
    chk("rst_pending", pending, 0);
    chk("rst_valid", req_valid, 0);
    chk("rst_floor", requested_floor, 0);
    chk("rst_dir", direction, 1);
    reset = 1'b1;
    tick();
    // first call: bit after one edge, target after two
    call(3);
    chk("c3_pending", pending, 'h008);
    chk("c3_valid_early", req_valid, 0);
    tick();
    chk("c3_valid", req_valid, 1);
    chk("c3_floor", requested_floor, 3);
    chk("c3_dir", direction, 1);
    arrive(3);
    tick();
    chk("idle_valid", req_valid, 0);
    chk("idle_hold_floor", requested_floor, 3);
    // retarget to a closer floor in the up sweep
    current_floor = 1;
    call(5);
    tick();
    chk("up5_floor", requested_floor, 5);
    call(3);
    chk("rt_pending", pending, 'h028);
    chk("rt_floor_old", requested_floor, 5);
    tick();
    chk("rt_floor_new", requested_floor, 3);
    arrive(3);
    chk("rt_clear", pending, 'h020);
    tick();
    chk("rt_back5", requested_floor, 5);
    chk("rt_dir", direction, 1);
    arrive(5);
    tick();
    // sweep reversal
    current_floor = 4;
    call(6);
    call(2);
    tick();
    chk("sw_floor6", requested_floor, 6);
    arrive(6);
    chk("sw_pending", pending, 'h004);
    tick();
    chk("sw_floor2", requested_floor, 2);
    chk("sw_dir_down", direction, 0);
    arrive(2);
    tick();
    chk("sw_idle", req_valid, 0);
    chk("sw_dir_hold", direction, 0);
    chk("sw_floor_hold", requested_floor, 2);
    // same-cycle call and clear
    current_floor = 3;
    call(3);
    arrived = 1'b1;
    call(3);
    chk("same_clear_wins", pending, 0);
    call(7);
    arrived = 1'b0;
    chk("other_call_kept", pending, 'h080);
    arrive(7);
    tick();
    // door hold
    current_floor = 2;
    call(8);
    tick();
    chk("door_floor8", requested_floor, 8);
    door_open = 1'b1;
    call(4);
    chk("door_pending", pending, 'h110);
    tick();
    tick();
    chk("door_frozen", requested_floor, 8);
    chk("door_valid", req_valid, 1);
    door_open = 1'b0;
    tick();
    chk("door_release", requested_floor, 4);
    call(15);
    chk("oor_ignored", pending, 'h110);
    // async reset mid-sweep
    arrive(4);
    call(2);
    call(5);
    chk("pre_rst_pending", pending, 'h124);
    current_floor = 9;
    tick();
    chk("pre_rst_dir", direction, 0);
    chk("pre_rst_floor", requested_floor, 8);
    #2 reset = 1'b0;
    #1;
    chk("arst_pending", pending, 0);
    chk("arst_valid", req_valid, 0);
    chk("arst_floor", requested_floor, 0);
    chk("arst_dir", direction, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
